// File: rtl/regfile_param.sv
// regfile_param: DEPTH x DW register file with a post-reset clear sweep, optional write-to-read bypass
// Ports: clk/rst (sync, active-high); we/wreg/wdata write port; rreg1/rreg2 -> rdata1/rdata2
// combinational read ports; busy high during the clear sweep; wr_done one-cycle write acknowledge.
module regfile_param #(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] wreg,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] rreg1,
    input  logic [AW-1:0] rreg2,
    output logic [DW-1:0] rdata1,
    output logic [DW-1:0] rdata2,
    output logic          busy,
    output logic          wr_done
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] LAST = (AW + 1)'(DEPTH - 1);

    typedef enum logic {CLEAR, READY} state_t;

    state_t        state_q, state_d;
    logic [AW:0]   sweep_idx_q, sweep_idx_d;
    logic          wr_done_q, wr_done_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic          wr_ok, byp1, byp2;

    assign wr_ok = state_q == READY && we && wreg != '0;
    assign byp1  = BYPASS != 0 && wr_ok && rreg1 == wreg;
    assign byp2  = BYPASS != 0 && wr_ok && rreg2 == wreg;

    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        wr_done_d   = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = wreg;
        mem_wdata   = wdata;
        if (state_q == CLEAR) begin
            mem_we      = !rst;
            mem_waddr   = sweep_idx_q[AW-1:0];
            mem_wdata   = '0;
            sweep_idx_d = sweep_idx_q + 1'b1;
            state_d     = sweep_idx_q == LAST ? READY : CLEAR;
        end else if (wr_ok) begin
            mem_we    = !rst;
            wr_done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLEAR;
            sweep_idx_q <= '0;
            wr_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweep_idx_q <= sweep_idx_d;
            wr_done_q   <= wr_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    assign busy    = state_q == CLEAR;
    assign wr_done = wr_done_q;
    assign rdata1  = (busy || rreg1 == '0) ? '0 : byp1 ? wdata : mem_q[rreg1];
    assign rdata2  = (busy || rreg2 == '0) ? '0 : byp2 ? wdata : mem_q[rreg2];
endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 SHALL provide parameter DW, default 32: data width in bits; legal range 1..64.
REQ-002 SHALL provide parameter AW, default 5: address width; depth is DEPTH = 2^AW registers; legal range 1..8.
REQ-003 SHALL provide parameter BYPASS, default 1: 1 = same-cycle write-to-read forwarding, 0 = no forwarding.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 SHALL have port we, input, 1 bit: write enable.
REQ-007 SHALL have port wreg, input, AW bits: write address.
REQ-008 SHALL have port wdata, input, DW bits: write data.
REQ-009 SHALL have ports rreg1 and rreg2, inputs, AW bits each: read addresses.
REQ-010 SHALL have ports rdata1 and rdata2, outputs, DW bits each: read data, combinational from the read addresses.
REQ-011 SHALL have port busy, output, 1 bit: 1 while the clear sweep runs.
REQ-012 SHALL have port wr_done, output, 1 bit: registered one-cycle pulse acknowledging an accepted write.

Function
REQ-013 SHALL implement a two-state FSM, CLEAR and READY; busy = 1 exactly when the state is CLEAR.
REQ-014 In CLEAR, each cycle SHALL write 0 to register sweep_idx and increment sweep_idx; sweep_idx is a counter of AW+1 bits.
REQ-015 The FSM SHALL move from CLEAR to READY on the edge that clears register DEPTH-1, so the sweep lasts exactly DEPTH cycles.
REQ-016 In CLEAR, the block SHALL ignore we and SHALL keep wr_done = 0.
REQ-017 In CLEAR, rdata1 and rdata2 SHALL read 0 regardless of address.
REQ-018 In READY, with we=1 and wreg != 0, the block SHALL store wdata in register wreg on the edge and SHALL drive wr_done = 1 in the following cycle.
REQ-019 A write to register 0 SHALL have no effect and SHALL keep wr_done = 0.
REQ-020 Register 0 SHALL always read 0 on both read ports.
REQ-021 With BYPASS=1, in READY, when we=1, wreg != 0 and rregN == wreg, rdataN SHALL equal wdata in the same cycle.
REQ-022 With BYPASS=0, under the REQ-021 conditions rdataN SHALL return the old contents until the edge.
REQ-023 Both read ports SHALL be independent; identical addresses on both ports SHALL return identical data.
REQ-024 Stored values SHALL persist indefinitely while we=0 or while wreg=0.

Reset
REQ-025 On any edge with rst=1, the block SHALL enter CLEAR, set sweep_idx to 0 and set wr_done to 0; from the next cycle busy reads 1 and rdata1/rdata2 read 0.
REQ-026 rst SHALL take priority over any write and over sweep progress.
REQ-027 rst asserted during a sweep SHALL restart the sweep from index 0.
REQ-028 rst held high SHALL keep the block in CLEAR at sweep_idx 0.
REQ-029 State before the first rst is unspecified; rst SHALL be asserted at least once before use.

Verification
REQ-030 Bench SHALL check sweep timing (AW=5): rst 1 cycle -> busy=1 for exactly 32 cycles, then 0; every register subsequently reads 0.
REQ-031 Bench SHALL check write/read: READY, write 0x0000_00A5 to reg 9 -> wr_done=1 next cycle; rreg1=9 reads 0x0000_00A5.
REQ-032 Bench SHALL check register 0: write 0xFFFF_FFFF to reg 0 -> wr_done=0; rdata1 with rreg1=0 reads 0.
REQ-033 Bench SHALL check bypass: BYPASS=1, reg 3 = 0x11, we=1, wreg=3, wdata=0x22, rreg2=3 -> rdata2=0x22 in the same cycle; with BYPASS=0 -> 0x11 until the edge.
REQ-034 Bench SHALL check writes ignored during the sweep: we=1, wreg=4, wdata=0x55 in cycle 3 of the sweep -> wr_done=0; reg 4 reads 0 after the sweep.
REQ-035 Bench SHALL check mid-sweep reset: rst at sweep cycle 10 -> busy stays 1 for 32 more cycles.
